// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
// Lookup is combinational on fetch_pc; resolved updates are written at the clock edge.
module branch_target_buffer #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] fetch_pc,
  output logic        token,
  output logic [31:0] PC_from_buf,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] hit_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_r  [DEPTH];
  logic [1:0]       ctr_r    [DEPTH];
  logic [TAG_W-1:0] tag_r    [DEPTH];
  logic [31:0]      target_r [DEPTH];
  logic [31:0]      hit_cnt_r;

  logic [IDX_W-1:0] fetch_idx_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] fetch_tag_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             fetch_hit_s;
  logic             upd_hit_s;
  logic [1:0]       ctr_cur_s;
  logic [1:0]       ctr_next_s;
  logic             wr_ctr_s;
  logic             wr_target_s;
  logic             unused_pc_bits_s;

  assign fetch_idx_s      = fetch_pc[IDX_W+1:2];
  assign fetch_tag_s      = fetch_pc[31:IDX_W+2];
  assign upd_idx_s        = upd_pc[IDX_W+1:2];
  assign upd_tag_s        = upd_pc[31:IDX_W+2];
  assign unused_pc_bits_s = ^{fetch_pc[1:0], upd_pc[1:0]};
  assign hit_cnt          = hit_cnt_r;

  // Same-cycle prediction from the current table contents.
  always_comb begin
    fetch_hit_s = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s);
    token       = resetn && fetch_hit_s && ctr_r[fetch_idx_s][1];
    if (token) begin
      PC_from_buf = target_r[fetch_idx_s];
    end else begin
      PC_from_buf = 32'h0000_0000;
    end
  end

  // Update decode: counter step on a hit, allocate only on a taken miss.
  always_comb begin
    upd_hit_s  = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    ctr_cur_s  = ctr_r[upd_idx_s];
    ctr_next_s = ctr_cur_s;
    if (!upd_hit_s) begin
      ctr_next_s = 2'b10;
    end else if (upd_taken) begin
      if (ctr_cur_s != 2'b11) begin
        ctr_next_s = ctr_cur_s + 2'b01;
      end else begin
        ctr_next_s = ctr_cur_s;
      end
    end else begin
      if (ctr_cur_s != 2'b00) begin
        ctr_next_s = ctr_cur_s - 2'b01;
      end else begin
        ctr_next_s = ctr_cur_s;
      end
    end
    wr_ctr_s    = resetn && upd_valid && (upd_hit_s || upd_taken);
    wr_target_s = resetn && upd_valid && upd_taken;
  end

  // Valid bits, counters and hit counter; reset leaves no entry usable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= 2'b01;
      end
      hit_cnt_r <= 32'h0000_0000;
    end else begin
      if (token) begin
        hit_cnt_r <= hit_cnt_r + 32'h0000_0001;
      end
      if (wr_ctr_s) begin
        valid_r[upd_idx_s] <= 1'b1;
        ctr_r[upd_idx_s]   <= ctr_next_s;
      end
    end
  end

  // Tag and target storage is gated by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_target_s) begin
      tag_r[upd_idx_s]    <= upd_tag_s;
      target_r[upd_idx_s] <= upd_target;
    end
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning table index width; the table has 2^IDX_W entries.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port fetch_pc, input, 32, the current fetch-stage PC to predict for.
REQ-005 SHALL have port token, output, 1, meaning predict taken and redirect fetch.
REQ-006 SHALL have port PC_from_buf, output, 32, the predicted target PC.
REQ-007 SHALL have port upd_valid, input, 1, a resolved control-transfer update this cycle.
REQ-008 SHALL have port upd_pc, input, 32, the PC of the resolved branch.
REQ-009 SHALL have port upd_taken, input, 1, the resolved direction.
REQ-010 SHALL have port upd_target, input, 32, the resolved target.
REQ-011 SHALL have port hit_cnt, output, 32, the count of lookups that produced token=1.

Function
REQ-012 SHALL index with pc[IDX_W+1:2], use pc[31:IDX_W+2] as the tag, and ignore pc[1:0].
REQ-013 SHALL hold per entry: valid (1 bit), tag, target (32 bits) and a 2-bit saturating counter ctr.
REQ-014 SHALL perform lookup combinationally from fetch_pc in the same cycle: hit = valid && tag match.
REQ-015 SHALL drive token = resetn && hit && ctr[1].
REQ-016 SHALL drive PC_from_buf = entry target when token=1, else 32'h00000000.
REQ-017 SHALL, on upd_valid with a tag hit and upd_taken=1: ctr = min(ctr+1, 3), target = upd_target.
REQ-018 SHALL, on upd_valid with a tag hit and upd_taken=0: ctr = max(ctr-1, 0), target unchanged.
REQ-019 SHALL, on upd_valid with a miss (invalid entry or tag mismatch) and upd_taken=1: allocate/overwrite with valid=1, new tag, target=upd_target, ctr=2'b10.
REQ-020 SHALL, on upd_valid with a miss and upd_taken=0: leave the entry unchanged (no allocation).
REQ-021 SHALL apply updates at the clock edge; the first cycle they are visible to lookup is the next cycle.
REQ-022 SHALL give a same-cycle lookup and update to one index the old entry contents (no bypass).
REQ-023 SHALL increment hit_cnt by 1 per cycle with token=1 and wrap from 32'hFFFFFFFF to 0.
REQ-024 SHALL ignore upd_pc, upd_taken and upd_target when upd_valid=0.

Reset
REQ-025 SHALL, at a rising edge with resetn=0: clear all valid bits, set all ctr to 2'b01, and clear hit_cnt to 0.
REQ-026 SHALL, with resetn=0, force token=0 and PC_from_buf=0 combinationally.
REQ-027 SHALL ignore any update that coincides with resetn=0.
REQ-028 SHALL predict not-taken for every PC in the first cycle after reset.
REQ-029 SHALL not require tag or target contents to be reset.

Verification
REQ-030 SHALL test post-reset lookup: fetch_pc=32'hbfc00000 -> token=0, PC_from_buf=0, hit_cnt=0.
REQ-031 SHALL test allocation: update pc=32'hbfc00010, taken=1, target=32'hbfc00100; then lookup of 32'hbfc00010 on the next cycle -> token=1, PC_from_buf=32'hbfc00100, hit_cnt increments to 1.
REQ-032 SHALL test hysteresis: from ctr=2'b10, one not-taken update -> ctr=2'b01, token=0; a further taken update -> token=1; three taken updates saturate ctr at 3, then one not-taken update leaves token=1.
REQ-033 SHALL test aliasing: allocate 32'hbfc00010, then a taken update for 32'hbfc00050 (same index, different tag) -> 32'hbfc00010 misses (token=0) and 32'hbfc00050 hits with its own target.
REQ-034 SHALL test same-cycle lookup and update to one index: the lookup returns the pre-update prediction, and the update is visible the next cycle.
REQ-035 SHALL test reset mid-operation: with populated entries, a resetn=0 pulse coinciding with upd_valid=1 -> all lookups token=0 afterwards, hit_cnt=0, and no entry written.
